// File: rtl/alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer
//
// Multi-cycle shift-and-add multiplier that borrows the execute-stage ALU.
// It issues one ALU operation per cycle, using only the AND, ADD, SLLI and
// SRLI opcodes, and returns the low DATA_W bits of op_a * op_b. The low word
// is the same for signed and unsigned operands, so no sign handling is needed.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high
//   in_valid      operand pair offered
//   in_ready      sequencer can accept (IDLE and not in reset)
//   op_a          multiplicand
//   op_b          multiplier
//   result_valid  product available (DONE state)
//   result_ready  consumer takes the product
//   result        low DATA_W bits of op_a * op_b
//   busy          high in any state other than IDLE
//   alu_op        drives ALU Operation
//   alu_srca      drives ALU SrcA
//   alu_srcb      drives ALU SrcB
//   alu_result    ALU result, combinational in the same cycle
// -----------------------------------------------------------------------------
module alu_mul_sequencer #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_srca,
  output logic [DATA_W-1:0] alu_srcb,
  input  logic [DATA_W-1:0] alu_result
);

  localparam logic [OP_W-1:0]   OP_AND  = OP_W'(4'b0000);
  localparam logic [OP_W-1:0]   OP_ADD  = OP_W'(4'b0010);
  localparam logic [OP_W-1:0]   OP_SLLI = OP_W'(4'b0110);
  localparam logic [OP_W-1:0]   OP_SRLI = OP_W'(4'b1110);
  localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TEST = 3'd1,
    S_ACC  = 3'd2,
    S_SHL  = 3'd3,
    S_SHR  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;

  logic              accept;
  logic              xfer;

  assign accept = in_valid && in_ready;
  assign xfer   = result_valid && result_ready;

  // State register: the only thing reset touches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A zero multiplier skips the loop entirely; otherwise
  // the loop runs until the logical right shift has drained the multiplier.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (op_b == '0) ? S_DONE : S_TEST;
        end
      end
      S_TEST: state_nxt = alu_result[0] ? S_ACC : S_SHL;
      S_ACC:  state_nxt = S_SHL;
      S_SHL:  state_nxt = S_SHR;
      S_SHR:  state_nxt = (alu_result == '0) ? S_DONE : S_TEST;
      S_DONE: begin
        if (xfer) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Working registers. They carry no reset: every operation reloads them on
  // accept, and the result port is gated to zero outside DONE, so stale
  // contents are never visible.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (accept) begin
          mcand  <= op_a;
          mplier <= op_b;
          acc    <= '0;
        end
      end
      S_ACC:   acc    <= alu_result;
      S_SHL:   mcand  <= alu_result;
      S_SHR:   mplier <= alu_result;
      default: ;
    endcase
  end

  // Output decode. Everything is forced low while reset is high, even if the
  // state register has not yet returned to IDLE.
  always_comb begin
    in_ready     = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    result       = '0;
    alu_op       = OP_AND;
    alu_srca     = '0;
    alu_srcb     = '0;
    if (!reset) begin
      busy = (state != S_IDLE);
      case (state)
        S_IDLE: in_ready = 1'b1;
        S_TEST: begin
          // Isolate bit 0 of the multiplier.
          alu_op   = OP_AND;
          alu_srca = mplier;
          alu_srcb = ONE;
        end
        S_ACC: begin
          alu_op   = OP_ADD;
          alu_srca = acc;
          alu_srcb = mcand;
        end
        S_SHL: begin
          alu_op   = OP_SLLI;
          alu_srca = mcand;
          alu_srcb = ONE;
        end
        S_SHR: begin
          alu_op   = OP_SRLI;
          alu_srca = mplier;
          alu_srcb = ONE;
        end
        S_DONE: begin
          result_valid = 1'b1;
          result       = acc;
        end
        default: ;
      endcase
    end
  end

endmodule
